// File: rtl/bp_gshare_pht_pkg.sv
// Shared types and helpers for the gshare/bimodal direction predictor.
// Helpers use 32-bit words so they stay width-generic; callers cast to their own widths.
package bp_gshare_pht_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    function automatic logic [31:0] ctr_max(input int ctr_w);
        return (32'd1 << ctr_w) - 32'd1;
    endfunction

    // Weakly-not-taken: MSB clear, every lower bit set.
    function automatic logic [31:0] weak_nt(input int ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_inc(input logic [31:0] ctr, input int ctr_w);
        return (ctr == ctr_max(ctr_w)) ? ctr : ctr + 32'd1;
    endfunction

    function automatic logic [31:0] ctr_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

    // PC bits above the instruction-word offset, optionally folded with history.
    function automatic logic [31:0] pht_index(input logic [31:0] pc, input logic [31:0] ghr,
                                              input int idx_w, input bit gshare);
        logic [31:0] mask;
        logic [31:0] pcidx;
        mask  = (32'd1 << idx_w) - 32'd1;
        pcidx = (pc >> 2) & mask;
        return gshare ? ((pcidx ^ ghr) & mask) : pcidx;
    endfunction

endpackage

// File: rtl/bp_gshare_pht_if.sv
// Fetch-side lookup and late-pipeline training bundle of the direction predictor.
interface bp_gshare_pht_if #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 8
);
    logic             ready;
    logic             lookup_valid;
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [GHR_W-1:0] pred_ghr;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_taken;
    logic             upd_mispredict;

    modport master (
        input  ready, pred_valid, pred_taken, pred_ghr,
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_ghr,
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict
    );
endinterface

// File: rtl/bp_gshare_pht_pht.sv
// Counter table: startup sweep to weak-not-taken, saturating training, and a
// combinational lookup port that sees a same-cycle update first.
module bp_gshare_pht_pht
    import bp_gshare_pht_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_ready,
    input  logic [IDX_W-1:0] i_lk_idx,
    output logic [CTR_W-1:0] o_lk_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);
    localparam int               DEPTH   = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_nt(CTR_W));

    logic [CTR_W-1:0] r_pht [DEPTH];
    bp_state_e        r_state;
    bp_state_e        w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic             w_we;
    logic [IDX_W-1:0] w_waddr;
    logic [CTR_W-1:0] w_wdata;
    logic [CTR_W-1:0] w_upd_cur;
    logic [CTR_W-1:0] w_upd_new;
    logic             w_upd_fire;

    assign w_upd_fire = (r_state == ST_RUN) && i_upd_en;
    assign w_upd_cur  = r_pht[i_upd_idx];
    assign w_upd_new  = i_upd_taken ? CTR_W'(ctr_inc(32'(w_upd_cur), CTR_W))
                                    : CTR_W'(ctr_dec(32'(w_upd_cur)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = i_upd_idx;
        w_wdata      = w_upd_new;
        case (r_state)
            ST_INIT: begin
                w_we    = 1'b1;
                w_waddr = r_ptr;
                w_wdata = WEAK_NT;
                if (r_ptr == '1) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_we = w_upd_fire;
            default: w_state_next = ST_INIT;
        endcase
    end

    // Table contents need no reset: the sweep rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_pht[w_waddr] <= w_wdata;
        end
    end

    assign o_lk_ctr = (w_upd_fire && (i_upd_idx == i_lk_idx)) ? w_upd_new : r_pht[i_lk_idx];
    assign o_ready  = (r_state == ST_RUN);

endmodule

// File: rtl/bp_gshare_pht.sv
// Direction predictor top: owns the speculative global history, the prediction
// register and the rule that mispredict repair beats the lookup shift.
module bp_gshare_pht
    import bp_gshare_pht_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 8,
    parameter int CTR_W = 2,
    parameter int GHR_W = 8,
    parameter int MODE  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bp_gshare_pht_if.slave bp
);
    logic             w_ready;
    logic             w_lk_fire;
    logic             w_upd_fire;
    logic [PC_W-1:0]  w_lk_pc;
    logic [PC_W-1:0]  w_upd_pc;
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [CTR_W-1:0] w_lk_ctr;
    logic             w_pred;
    logic [GHR_W-1:0] r_ghr;
    logic [GHR_W-1:0] w_ghr_next;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [GHR_W-1:0] r_pred_ghr;

    assign w_lk_pc    = bp.lookup_pc;
    assign w_upd_pc   = bp.upd_pc;
    assign w_lk_fire  = w_ready & bp.lookup_valid;
    assign w_upd_fire = w_ready & bp.upd_valid;

    // The update side indexes with the history it was predicted under, never the live GHR.
    assign w_lk_idx  = IDX_W'(pht_index(32'(w_lk_pc), 32'(r_ghr), IDX_W, MODE != 0));
    assign w_upd_idx = IDX_W'(pht_index(32'(w_upd_pc), 32'(bp.upd_ghr), IDX_W, MODE != 0));
    assign w_pred    = w_lk_ctr[CTR_W-1];

    bp_gshare_pht_pht #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_ready     (w_ready),
        .i_lk_idx    (w_lk_idx),
        .o_lk_ctr    (w_lk_ctr),
        .i_upd_en    (w_upd_fire),
        .i_upd_idx   (w_upd_idx),
        .i_upd_taken (bp.upd_taken)
    );

    // Concatenate-then-truncate keeps the newest GHR_W bits, which also covers GHR_W=1.
    always_comb begin
        w_ghr_next = r_ghr;
        if (w_upd_fire && bp.upd_mispredict) begin
            w_ghr_next = GHR_W'({bp.upd_ghr, bp.upd_taken});
        end else if (w_lk_fire) begin
            w_ghr_next = GHR_W'({r_ghr, w_pred});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_ghr   <= '0;
        end else begin
            r_ghr        <= w_ghr_next;
            r_pred_valid <= w_lk_fire;
            if (w_lk_fire) begin
                r_pred_taken <= w_pred;
                r_pred_ghr   <= r_ghr;
            end
        end
    end

    assign bp.ready      = w_ready;
    assign bp.pred_valid = r_pred_valid;
    assign bp.pred_taken = r_pred_taken;
    assign bp.pred_ghr   = r_pred_ghr;

endmodule

// File: tb/tb_bp_gshare_pht.sv
// Drives a bimodal and a gshare instance with identical traffic and checks both
// against a behavioural table/history model.
module tb_bp_gshare_pht;
    localparam int PC_W    = 32;
    localparam int IDX_W   = 8;
    localparam int CTR_W   = 2;
    localparam int GHR_W   = 8;
    localparam int DEPTH   = 256;
    localparam int CTR_MAX = 3;
    localparam int WEAK_NT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic             lv = 1'b0, uv = 1'b0, ut = 1'b0, um = 1'b0;
    logic [PC_W-1:0]  lpc = '0, upc = '0;
    logic [GHR_W-1:0] ughr = '0;

    bp_gshare_pht_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bus_b ();
    bp_gshare_pht_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bus_g ();

    assign bus_b.lookup_valid = lv;   assign bus_g.lookup_valid = lv;
    assign bus_b.lookup_pc = lpc;     assign bus_g.lookup_pc = lpc;
    assign bus_b.upd_valid = uv;      assign bus_g.upd_valid = uv;
    assign bus_b.upd_pc = upc;        assign bus_g.upd_pc = upc;
    assign bus_b.upd_ghr = ughr;      assign bus_g.upd_ghr = ughr;
    assign bus_b.upd_taken = ut;      assign bus_g.upd_taken = ut;
    assign bus_b.upd_mispredict = um; assign bus_g.upd_mispredict = um;

    bp_gshare_pht #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bp(bus_b));
    bp_gshare_pht #(.PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .MODE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .bp(bus_g));

    // Index 0 = bimodal instance, 1 = gshare instance.
    logic             obs_rdy [2];
    logic             obs_pv [2];
    logic             obs_pt [2];
    logic [GHR_W-1:0] obs_pg [2];
    assign obs_rdy[0] = bus_b.ready;      assign obs_rdy[1] = bus_g.ready;
    assign obs_pv[0]  = bus_b.pred_valid; assign obs_pv[1]  = bus_g.pred_valid;
    assign obs_pt[0]  = bus_b.pred_taken; assign obs_pt[1]  = bus_g.pred_taken;
    assign obs_pg[0]  = bus_b.pred_ghr;   assign obs_pg[1]  = bus_g.pred_ghr;

    int n_tests = 0;
    int n_fail  = 0;

    int m_pht [2][DEPTH];
    int m_ghr [2];
    int m_init;
    bit e_rdy;
    bit e_pv [2];
    bit e_pt [2];
    int e_pg [2];

    always #5 clk = ~clk;

    function automatic int ref_idx(input int m, input int pc, input int g);
        int pcidx;
        pcidx = (pc / 4) % DEPTH;
        return (m == 1) ? (pcidx ^ g) : pcidx;
    endfunction

    // One clock of traffic; afterwards the model holds what both DUTs should show.
    task automatic step(input bit l_v, input int l_pc, input bit u_v, input int u_pc,
                        input int u_g, input bit u_t, input bit u_m);
        bit rdy;
        int lidx, uidx, c, newc;
        bit p;
        lv = l_v; lpc = l_pc; uv = u_v; upc = u_pc; ughr = u_g[GHR_W-1:0]; ut = u_t; um = u_m;
        rdy = (m_init >= DEPTH);
        @(posedge clk);
        #1;
        if (!rdy) begin
            for (int m = 0; m < 2; m++) begin
                m_pht[m][m_init] = WEAK_NT;
                e_pv[m] = 1'b0;
            end
            m_init++;
        end else begin
            for (int m = 0; m < 2; m++) begin
                uidx = -1;
                newc = 0;
                p    = 1'b0;
                if (u_v) begin
                    uidx = ref_idx(m, u_pc, u_g);
                    c    = m_pht[m][uidx];
                    newc = u_t ? ((c < CTR_MAX) ? c + 1 : CTR_MAX) : ((c > 0) ? c - 1 : 0);
                end
                e_pv[m] = l_v;
                if (l_v) begin
                    lidx    = ref_idx(m, l_pc, m_ghr[m]);
                    c       = (u_v && lidx == uidx) ? newc : m_pht[m][lidx];
                    p       = (c >= 2);
                    e_pt[m] = p;
                    e_pg[m] = m_ghr[m];
                end
                if (u_v) m_pht[m][uidx] = newc;
                if (u_v && u_m)  m_ghr[m] = (u_g * 2 + int'(u_t)) % DEPTH;
                else if (l_v)    m_ghr[m] = (m_ghr[m] * 2 + int'(p)) % DEPTH;
            end
        end
        e_rdy = (m_init >= DEPTH);
        lv = 1'b0; uv = 1'b0; um = 1'b0;
    endtask

    task automatic apply_reset_now();
        lv = 1'b0; uv = 1'b0; um = 1'b0;
        rst_n  = 1'b0;
        m_init = 0;
        e_rdy  = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_ghr[m] = 0; e_pv[m] = 1'b0; e_pt[m] = 1'b0; e_pg[m] = 0;
        end
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_and_sweep();
        apply_reset_now();
        release_reset();
        idle(DEPTH);
    endtask

    task automatic test_reset();
        apply_reset_now();
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_rdy[m] !== e_rdy) begin n_fail++; $display("FAIL rst_ready m%0d: got %0b want %0b", m, obs_rdy[m], e_rdy); end
            n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL rst_pvalid m%0d: got %0b want %0b", m, obs_pv[m], e_pv[m]); end
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL rst_ptaken m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
            n_tests++; if (obs_pg[m] !== GHR_W'(e_pg[m])) begin n_fail++; $display("FAIL rst_pghr m%0d: got %0h want %0h", m, obs_pg[m], e_pg[m]); end
        end
        release_reset();
        // Random lookups/updates during the sweep must be ignored.
        for (int c = 0; c < DEPTH; c++) begin
            step(1'($urandom), int'($urandom_range(0, 'hFFFF)), 1'($urandom), int'($urandom_range(0, 'hFFFF)),
                 int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
            for (int m = 0; m < 2; m++) begin
                n_tests++; if (obs_rdy[m] !== e_rdy) begin n_fail++; $display("FAIL sweep_ready m%0d cyc%0d: got %0b want %0b", m, c, obs_rdy[m], e_rdy); end
                n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL sweep_pvalid m%0d cyc%0d: got %0b want %0b", m, c, obs_pv[m], e_pv[m]); end
            end
        end
        step(1, 'h100, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL first_pvalid m%0d: got %0b want %0b", m, obs_pv[m], e_pv[m]); end
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL first_ptaken m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_bimodal();
        int seq_n [3] = '{2, 5, 0};
        for (int phase = 0; phase < 3; phase++) begin
            for (int i = 0; i < seq_n[phase]; i++) step(0, 0, 1, 'h40, 0, 1, 0);
            if (phase == 1) step(0, 0, 1, 'h40, 0, 0, 0);
            if (phase == 2) begin step(0, 0, 1, 'h40, 0, 0, 0); step(0, 0, 1, 'h40, 0, 0, 0); end
            step(1, 'h40, 0, 0, 0, 0, 0);
            for (int m = 0; m < 2; m++) begin
                n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL bimodal_ptaken m%0d ph%0d: got %0b want %0b", m, phase, obs_pt[m], e_pt[m]); end
            end
        end
        $display("[TB] test_bimodal done");
    endtask

    task automatic test_gshare_history();
        int hist [3] = '{0, 1, 3};
        reset_and_sweep();
        for (int h = 0; h < 3; h++) begin
            step(0, 0, 1, 'h200, hist[h], 1, 0);
            step(0, 0, 1, 'h200, hist[h], 1, 0);
        end
        for (int k = 0; k < 4; k++) begin
            step(1, 'h200, 0, 0, 0, 0, 0);
            for (int m = 0; m < 2; m++) begin
                n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL hist_pvalid m%0d k%0d: got %0b want %0b", m, k, obs_pv[m], e_pv[m]); end
                n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL hist_ptaken m%0d k%0d: got %0b want %0b", m, k, obs_pt[m], e_pt[m]); end
                n_tests++; if (obs_pg[m] !== GHR_W'(e_pg[m])) begin n_fail++; $display("FAIL hist_pghr m%0d k%0d: got %0h want %0h", m, k, obs_pg[m], e_pg[m]); end
            end
        end
        $display("[TB] test_gshare_history done");
    endtask

    task automatic test_repair();
        step(1, 'h300, 1, 'h500, 'h5A, 1, 1);
        step(1, 'h300, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_pg[m] !== GHR_W'(e_pg[m])) begin n_fail++; $display("FAIL repair_pghr m%0d: got %0h want %0h", m, obs_pg[m], e_pg[m]); end
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL repair_ptaken m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
        end
        $display("[TB] test_repair done");
    endtask

    task automatic test_bypass();
        reset_and_sweep();
        // Same idx in both modes: same PC, and upd_ghr equals the live history.
        step(1, 'h3F0, 1, 'h3F0, m_ghr[1], 1, 0);
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL bypass_inc m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
        end
        step(0, 0, 1, 'h800, 0, 0, 1);
        step(1, 'h3F0, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL bypass_stored m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
        end
        step(0, 0, 1, 'h800, 0, 0, 1);
        step(1, 'h3F0, 1, 'h3F0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL bypass_dec m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
        end
        $display("[TB] test_bypass done");
    endtask

    task automatic test_reset_mid();
        apply_reset_now();
        release_reset();
        idle(100);
        apply_reset_now();
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_rdy[m] !== e_rdy) begin n_fail++; $display("FAIL mid_ready m%0d: got %0b want %0b", m, obs_rdy[m], e_rdy); end
            n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL mid_pvalid m%0d: got %0b want %0b", m, obs_pv[m], e_pv[m]); end
        end
        release_reset();
        idle(DEPTH);
        step(0, 0, 1, 'h40, 0, 1, 0);
        step(0, 0, 1, 'h40, 0, 1, 0);
        step(1, 'h40, 0, 0, 0, 0, 0);
        step(1, 'h40, 0, 0, 0, 0, 0);
        apply_reset_now();
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_rdy[m] !== e_rdy) begin n_fail++; $display("FAIL trained_rst_ready m%0d: got %0b want %0b", m, obs_rdy[m], e_rdy); end
            n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL trained_rst_pvalid m%0d: got %0b want %0b", m, obs_pv[m], e_pv[m]); end
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL trained_rst_ptaken m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
            n_tests++; if (obs_pg[m] !== GHR_W'(e_pg[m])) begin n_fail++; $display("FAIL trained_rst_pghr m%0d: got %0h want %0h", m, obs_pg[m], e_pg[m]); end
        end
        release_reset();
        for (int c = 0; c < DEPTH; c++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            for (int m = 0; m < 2; m++) begin
                n_tests++; if (obs_rdy[m] !== e_rdy) begin n_fail++; $display("FAIL resweep_ready m%0d cyc%0d: got %0b want %0b", m, c, obs_rdy[m], e_rdy); end
            end
        end
        step(1, 'h40, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL lost_training m%0d: got %0b want %0b", m, obs_pt[m], e_pt[m]); end
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 1500; c++) begin
            g = ($urandom_range(0, 1) == 0) ? m_ghr[1] : int'($urandom_range(0, 255));
            step(1'($urandom), int'($urandom_range(0, 15)) * 4, 1'($urandom), int'($urandom_range(0, 15)) * 4,
                 g, 1'($urandom), ($urandom_range(0, 7) == 0));
            for (int m = 0; m < 2; m++) begin
                n_tests++; if (obs_rdy[m] !== e_rdy) begin n_fail++; $display("FAIL rnd_ready m%0d cyc%0d: got %0b want %0b", m, c, obs_rdy[m], e_rdy); end
                n_tests++; if (obs_pv[m] !== e_pv[m]) begin n_fail++; $display("FAIL rnd_pvalid m%0d cyc%0d: got %0b want %0b", m, c, obs_pv[m], e_pv[m]); end
                n_tests++; if (obs_pt[m] !== e_pt[m]) begin n_fail++; $display("FAIL rnd_ptaken m%0d cyc%0d: got %0b want %0b", m, c, obs_pt[m], e_pt[m]); end
                n_tests++; if (obs_pg[m] !== GHR_W'(e_pg[m])) begin n_fail++; $display("FAIL rnd_pghr m%0d cyc%0d: got %0h want %0h", m, c, obs_pg[m], e_pg[m]); end
            end
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_bimodal();
        test_gshare_history();
        test_repair();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
